instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage that consumes the program counter value and issues instruction-memory reads at that address. Holds the returned word in an instruction register and presents it to decode with a valid/ready handshake. Drives the PC's increment and load controls; a branch/jump redirect from execute loads a new PC and squashes the fetch in flight. Multicycle design: at most one instruction is in flight.

Parameters:
DATA_WIDTH, 16, instruction word width
ADDR_WIDTH, 16, address width; equals the PC width

Ports:
clk  input  1  clock, rising-edge
clr  input  1  reset, asynchronous, active-low
pc_in  input  ADDR_WIDTH  current PC value (counter output)
pc_up  output  1  increment PC at the next edge
pc_load  output  1  load pc_target into PC at the next edge
pc_target  output  ADDR_WIDTH  PC load value
imem_req  output  1  memory read request, level
imem_addr  output  ADDR_WIDTH  read address
imem_ack  input  1  read data valid this cycle
imem_rdata  input  DATA_WIDTH  read data
ir_out  output  DATA_WIDTH  instruction register
ir_pc  output  ADDR_WIDTH  address ir_out was fetched from
ir_valid  output  1  ir_out holds an unconsumed instruction
ir_ready  input  1  decode accepts ir_out this cycle
redirect  input  1  branch/jump taken, 1-cycle pulse or level
redirect_addr  input  ADDR_WIDTH  branch target

Behaviour:
- Registered state: state, fetch_addr, ir_out, ir_pc, ir_valid. Reset (clr=0, async) sets state=ADDR and all other registers to 0.
- Combinational outputs are 0 whenever state is not driving them:
  - imem_req = (state==FETCH or DRAIN)
  - imem_addr = fetch_addr
  - pc_load = redirect (in any state)
  - pc_target = redirect_addr
  - pc_up = (state==FETCH and imem_ack and not redirect)
  - pc_up and pc_load are never high together.
- ADDR:
  - fetch_addr <= pc_in; go to FETCH.
  - If redirect: stay in ADDR (PC loads this edge; resample next cycle).
- FETCH:
  - imem_req=1; fetch_addr is held stable while waiting.
  - imem_ack and no redirect: ir_out<=imem_rdata, ir_pc<=fetch_addr, ir_valid<=1, pc_up=1; go to HOLD.
  - imem_ack and redirect: data discarded, PC loaded; go to ADDR.
  - No ack: stay in FETCH (unbounded wait).
  - No ack and redirect: go to DRAIN.
- DRAIN:
  - imem_req stays 1 at the old fetch_addr until imem_ack; the data is discarded; then go to ADDR.
  - A redirect in DRAIN loads the PC again (newest target wins); stay in DRAIN.
- HOLD:
  - ir_valid=1; ir_out and ir_pc stay stable.
  - ir_ready: ir_valid<=0; go to ADDR.
  - redirect (with or without ir_ready): ir_valid<=0, the transfer does not count as accepted; go to ADDR.
- Latency with zero-wait memory, per instruction:
  - ADDR at cycle 0, FETCH plus ack at cycle 1, ir_valid high at cycle 2.
  - Best case one instruction every 3 cycles.
- Address arithmetic is owned by the PC; wrap-around from 0xFFFF to 0x0000 is transparent here.
- Reset mid-fetch: the request drops immediately (imem_req is combinational from state). The memory must tolerate an abandoned request only under reset.

Test Plan:
- Reset with pc_in=0x0000, zero-wait memory returning 0xA5A5 -> cycle 1: imem_req=1, imem_addr=0x0000; pc_up=1 for one cycle; cycle 2: ir_valid=1, ir_out=0xA5A5, ir_pc=0x0000.
- imem_ack delayed 3 cycles at addr 0x0010 -> imem_req and imem_addr=0x0010 held for 4 cycles; pc_up only in the ack cycle; exactly one PC increment.
- ir_ready low for 5 cycles in HOLD -> ir_out and ir_pc stable; no new imem_req; ir_ready=1 -> ir_valid=0 next cycle; next fetch at 0x0011.
- redirect with redirect_addr=0x0200 while in HOLD -> pc_load=1, pc_target=0x0200, ir_valid=0 next cycle; next imem_addr=0x0200.
- redirect in FETCH before ack (addr 0x0005) -> DRAIN with imem_addr=0x0005 until ack; data not written to ir_out; pc_up never asserted; next fetch at the target.
- clr pulsed low while in FETCH -> imem_req=0, ir_valid=0, ir_out=0 immediately; after release, the fetch restarts from ADDR.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage bus bundle.
// Carries the PC controls (pc_in, pc_up, pc_load, pc_target), the
// instruction-memory read channel (imem_req, imem_addr, imem_ack, imem_rdata),
// the decode handshake (ir_out, ir_pc, ir_valid, ir_ready) and the execute
// redirect (redirect, redirect_addr).
// master: the fetch stage; slave: the PC, memory, decode and execute around it.
interface instruction_fetch_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] pc_in;
   logic                  pc_up;
   logic                  pc_load;
   logic [ADDR_WIDTH-1:0] pc_target;
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_ack;
   logic [DATA_WIDTH-1:0] imem_rdata;
   logic [DATA_WIDTH-1:0] ir_out;
   logic [ADDR_WIDTH-1:0] ir_pc;
   logic                  ir_valid;
   logic                  ir_ready;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_addr;

   modport master (
      input  pc_in, imem_ack, imem_rdata, ir_ready, redirect, redirect_addr,
      output pc_up, pc_load, pc_target, imem_req, imem_addr, ir_out, ir_pc, ir_valid
   );

   modport slave (
      output pc_in, imem_ack, imem_rdata, ir_ready, redirect, redirect_addr,
      input  pc_up, pc_load, pc_target, imem_req, imem_addr, ir_out, ir_pc, ir_valid
   );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: multicycle fetch stage, at most one instruction in flight.
// Ports: clk (rising edge), clr (async active-low reset), bus (master side of
// instruction_fetch_if: PC controls, imem read channel, decode handshake,
// execute redirect).
module instruction_fetch #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) (
   input logic                 clk,
   input logic                 clr,
   instruction_fetch_if.master bus
);
   typedef enum logic [1:0] {ADDR, FETCH, DRAIN, HOLD} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
   logic [DATA_WIDTH-1:0] ir_out_q, ir_out_d;
   logic [ADDR_WIDTH-1:0] ir_pc_q, ir_pc_d;
   logic                  ir_valid_q, ir_valid_d;
   logic                  req;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q      <= ADDR;
         fetch_addr_q <= '0;
         ir_out_q     <= '0;
         ir_pc_q      <= '0;
         ir_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         ir_out_q     <= ir_out_d;
         ir_pc_q      <= ir_pc_d;
         ir_valid_q   <= ir_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      ir_out_d     = ir_out_q;
      ir_pc_d      = ir_pc_q;
      ir_valid_d   = ir_valid_q;
      case (state_q)
         ADDR: begin
            // A redirect loads the PC this edge, so pc_in is stale; resample next cycle.
            fetch_addr_d = bus.pc_in;
            state_d      = bus.redirect ? ADDR : FETCH;
         end
         FETCH: begin
            if (bus.imem_ack && !bus.redirect) begin
               ir_out_d   = bus.imem_rdata;
               ir_pc_d    = fetch_addr_q;
               ir_valid_d = 1'b1;
               state_d    = HOLD;
            end else if (bus.imem_ack) begin
               state_d = ADDR;
            end else if (bus.redirect) begin
               // Outstanding read must still complete; its data is thrown away.
               state_d = DRAIN;
            end
         end
         DRAIN: state_d = bus.imem_ack ? ADDR : DRAIN;
         HOLD: begin
            // A redirect squashes the held instruction even if decode is ready.
            if (bus.ir_ready || bus.redirect) begin
               ir_valid_d = 1'b0;
               state_d    = ADDR;
            end
         end
         default: state_d = ADDR;
      endcase
   end

   assign req           = (state_q == FETCH) || (state_q == DRAIN);
   assign bus.imem_req  = req;
   assign bus.imem_addr = req ? fetch_addr_q : '0;
   assign bus.pc_load   = bus.redirect;
   assign bus.pc_target = bus.redirect ? bus.redirect_addr : '0;
   assign bus.pc_up     = (state_q == FETCH) && bus.imem_ack && !bus.redirect;
   assign bus.ir_out    = ir_out_q;
   assign bus.ir_pc     = ir_pc_q;
   assign bus.ir_valid  = ir_valid_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;
   logic clk = 1'b0;
   logic clr = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   up_cnt = 0;
   int   up_base;
   logic        pc_set_en = 1'b0;
   logic [15:0] pc_set_val = '0;
   logic [15:0] pc = '0;

   instruction_fetch_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

   instruction_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   assign bus.pc_in = pc;

   always @(posedge clk) begin
      if (pc_set_en) pc <= pc_set_val;
      else if (bus.pc_load) pc <= bus.pc_target;
      else if (bus.pc_up) pc <= pc + 16'd1;
      if (bus.pc_up) up_cnt <= up_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      pc_set_en = 1'b0;
   endtask

   initial begin
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      bus.ir_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_addr = '0;
      pc_set_en = 1'b1;
      pc_set_val = 16'h0000;
      step();
      step();
      check("rst_req", bus.imem_req, 0);
      check("rst_valid", bus.ir_valid, 0);
      check("rst_ir", bus.ir_out, 0);
      check("rst_irpc", bus.ir_pc, 0);
      check("rst_up", bus.pc_up, 0);
      // zero-wait fetch from 0x0000
      clr = 1'b1;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 16'hA5A5;
      #1 check("c0_req", bus.imem_req, 0);
      step();
      check("c1_req", bus.imem_req, 1);
      check("c1_addr", bus.imem_addr, 16'h0000);
      check("c1_up", bus.pc_up, 1);
      step();
      check("c2_valid", bus.ir_valid, 1);
      check("c2_ir", bus.ir_out, 16'hA5A5);
      check("c2_irpc", bus.ir_pc, 16'h0000);
      check("c2_up", bus.pc_up, 0);
      check("c2_req", bus.imem_req, 0);
      check("c2_pc", pc, 16'h0001);
      // delayed ack at 0x0010
      bus.imem_ack = 1'b0;
      bus.ir_ready = 1'b1;
      pc_set_en = 1'b1;
      pc_set_val = 16'h0010;
      step();
      bus.ir_ready = 1'b0;
      check("d_valid0", bus.ir_valid, 0);
      up_base = up_cnt;
      step();
      for (int i = 0; i < 3; i++) begin
         check("d_wait_req", bus.imem_req, 1);
         check("d_wait_addr", bus.imem_addr, 16'h0010);
         check("d_wait_up", bus.pc_up, 0);
         step();
      end
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 16'h1234;
      #1 check("d_ack_req", bus.imem_req, 1);
      check("d_ack_addr", bus.imem_addr, 16'h0010);
      check("d_ack_up", bus.pc_up, 1);
      step();
      bus.imem_ack = 1'b0;
      check("d_ir", bus.ir_out, 16'h1234);
      check("d_irpc", bus.ir_pc, 16'h0010);
      check("d_ups", up_cnt - up_base, 1);
      check("d_pc", pc, 16'h0011);
      // decode stalls 5 cycles
      for (int i = 0; i < 5; i++) begin
         step();
         check("h_valid", bus.ir_valid, 1);
         check("h_ir", bus.ir_out, 16'h1234);
         check("h_irpc", bus.ir_pc, 16'h0010);
         check("h_req", bus.imem_req, 0);
      end
      bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;
      check("h_valid0", bus.ir_valid, 0);
      step();
      check("h_next_addr", bus.imem_addr, 16'h0011);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 16'hBEEF;
      step();
      bus.imem_ack = 1'b0;
      check("h_next_irpc", bus.ir_pc, 16'h0011);
      // redirect while holding
      bus.redirect = 1'b1;
      bus.redirect_addr = 16'h0200;
      #1 check("r_load", bus.pc_load, 1);
      check("r_target", bus.pc_target, 16'h0200);
      check("r_up", bus.pc_up, 0);
      step();
      bus.redirect = 1'b0;
      check("r_valid0", bus.ir_valid, 0);
      check("r_pc", pc, 16'h0200);
      step();
      check("r_addr", bus.imem_addr, 16'h0200);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 16'h1111;
      step();
      bus.imem_ack = 1'b0;
      check("r_irpc", bus.ir_pc, 16'h0200);
      // redirect before ack at 0x0005 -> drain
      bus.ir_ready = 1'b1;
      pc_set_en = 1'b1;
      pc_set_val = 16'h0005;
      step();
      bus.ir_ready = 1'b0;
      up_base = up_cnt;
      step();
      check("x_addr", bus.imem_addr, 16'h0005);
      bus.redirect = 1'b1;
      bus.redirect_addr = 16'h0300;
      #1 check("x_up", bus.pc_up, 0);
      step();
      bus.redirect = 1'b0;
      check("x_dr_req", bus.imem_req, 1);
      check("x_dr_addr", bus.imem_addr, 16'h0005);
      step();
      check("x_dr_addr2", bus.imem_addr, 16'h0005);
      bus.redirect = 1'b1;
      bus.redirect_addr = 16'h0400;
      #1 check("x_dr_load", bus.pc_load, 1);
      step();
      bus.redirect = 1'b0;
      check("x_dr_req2", bus.imem_req, 1);
      check("x_pc", pc, 16'h0400);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 16'hDEAD;
      #1 check("x_ack_up", bus.pc_up, 0);
      check("x_ack_addr", bus.imem_addr, 16'h0005);
      step();
      bus.imem_ack = 1'b0;
      check("x_req0", bus.imem_req, 0);
      check("x_valid0", bus.ir_valid, 0);
      check("x_ir", bus.ir_out, 16'h1111);
      check("x_ups", up_cnt - up_base, 0);
      step();
      check("x_new_addr", bus.imem_addr, 16'h0400);
      // async reset mid-fetch
      clr = 1'b0;
      #1 check("a_req", bus.imem_req, 0);
      check("a_valid", bus.ir_valid, 0);
      check("a_ir", bus.ir_out, 0);
      step();
      check("a_req_held", bus.imem_req, 0);
      clr = 1'b1;
      step();
      check("a_restart_req", bus.imem_req, 1);
      check("a_restart_addr", bus.imem_addr, 16'h0400);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
